csr_seq_ctrl: RTL and testbench

Sequencer for the RV32 machine-mode CSR datapath. It accepts Zicsr instruction requests, trap-entry requests and MRET requests, arbitrates them, and drives the CSR file's read/write port one access per cycle. It performs the read-modify-write for CSRRW/RS/RC and their immediate forms, with the operand already selected by the pre-data mux. It also sequences the multi-register updates of trap entry (mepc, mcause, mstatus) and MRET (mstatus). It sits between decode/execute and the CSR register file and stalls the pipeline while busy.

---
 rtl/riscv_csr_pkg.sv | 51 +++++
 rtl/csr_seq_ctrl_if.sv | 39 +++
 rtl/csr_rmw_unit.sv | 56 +++++
 rtl/csr_seq_ctrl.sv | 118 +++++++++++
 tb/tb_csr_seq_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_csr_pkg.sv
// Shared CSR definitions for the machine-mode CSR sequencer: addresses,
// funct3 encodings, mstatus field positions, FSM states and mstatus helpers.
package riscv_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MISA    = 12'h301;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CSR_RD     = 3'd1,
    ST_CSR_WR     = 3'd2,
    ST_TRAP_EPC   = 3'd3,
    ST_TRAP_CAUSE = 3'd4,
    ST_TRAP_STAT  = 3'd5,
    ST_MRET_RD    = 3'd6,
    ST_MRET_WR    = 3'd7
  } csr_state_e;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
    logic [31:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

// File: rtl/csr_seq_ctrl_if.sv
// Request/CSR-file bundle between the pipeline, the sequencer and the CSR file.
interface csr_seq_ctrl_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
);
  logic              csr_req_in;
  logic [2:0]        csr_op_in;
  logic [ADDR_W-1:0] csr_addr_in;
  logic [XLEN-1:0]   pre_data_in;
  logic              src_zero_in;
  logic              trap_req_in;
  logic [XLEN-1:0]   trap_pc_in;
  logic [XLEN-1:0]   trap_cause_in;
  logic              mret_req_in;
  logic [XLEN-1:0]   csr_rd_data_in;
  logic [ADDR_W-1:0] csr_addr_out;
  logic              csr_wr_en_out;
  logic [XLEN-1:0]   csr_wr_data_out;
  logic [XLEN-1:0]   rd_data_out;
  logic              csr_done_out;
  logic              trap_done_out;
  logic              mret_done_out;
  logic              illegal_out;
  logic              stall_out;

  modport slave (
    input  csr_req_in, csr_op_in, csr_addr_in, pre_data_in, src_zero_in,
           trap_req_in, trap_pc_in, trap_cause_in, mret_req_in, csr_rd_data_in,
    output csr_addr_out, csr_wr_en_out, csr_wr_data_out, rd_data_out,
           csr_done_out, trap_done_out, mret_done_out, illegal_out, stall_out
  );

  modport master (
    output csr_req_in, csr_op_in, csr_addr_in, pre_data_in, src_zero_in,
           trap_req_in, trap_pc_in, trap_cause_in, mret_req_in, csr_rd_data_in,
    input  csr_addr_out, csr_wr_en_out, csr_wr_data_out, rd_data_out,
           csr_done_out, trap_done_out, mret_done_out, illegal_out, stall_out
  );
endinterface

// File: rtl/csr_rmw_unit.sv
// Combinational read-modify-write for Zicsr ops: new value, write enable and
// illegal-access detection from funct3, old value, operand and address.
module csr_rmw_unit
  import riscv_csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic [2:0]        op_i,
  input  logic [XLEN-1:0]   old_i,
  input  logic [XLEN-1:0]   pre_data_i,
  input  logic              src_zero_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [XLEN-1:0]   new_value_o,
  output logic              write_enable_o,
  output logic              illegal_o
);

  logic legal_op_s;
  logic wants_write_s;
  logic read_only_s;
  logic is_misa_s;

  assign read_only_s = (addr_i[ADDR_W-1 -: 2] == 2'b11);
  assign is_misa_s   = (addr_i == ADDR_W'(CSR_MISA));

  // Set/clear with a zero source are pure reads; RW forms always write.
  always_comb begin
    legal_op_s    = 1'b1;
    wants_write_s = 1'b0;
    new_value_o   = {XLEN{1'b0}};
    case (op_i)
      F3_RW, F3_RWI: begin
        new_value_o   = pre_data_i;
        wants_write_s = 1'b1;
      end
      F3_RS, F3_RSI: begin
        new_value_o   = old_i | pre_data_i;
        wants_write_s = ~src_zero_i;
      end
      F3_RC, F3_RCI: begin
        new_value_o   = old_i & ~pre_data_i;
        wants_write_s = ~src_zero_i;
      end
      default: begin
        legal_op_s    = 1'b0;
        wants_write_s = 1'b0;
      end
    endcase
  end

  // misa is silently read-only; the 2'b11 address block traps on write.
  assign write_enable_o = wants_write_s & ~read_only_s & ~is_misa_s;
  assign illegal_o      = ~legal_op_s | (wants_write_s & read_only_s);

endmodule

// File: rtl/csr_seq_ctrl.sv
// Machine-mode CSR sequencer: arbitrates trap/MRET/Zicsr requests and drives
// the CSR file one access per cycle, stalling the pipeline while busy.
module csr_seq_ctrl
  import riscv_csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 12
) (
  input  logic           clk_in,
  input  logic           rst_in,
  csr_seq_ctrl_if.slave  bus
);

  csr_state_e      state_q, state_d;
  logic [XLEN-1:0] old_q, old_d;
  logic [XLEN-1:0] rmw_new_s;
  logic            rmw_we_s;
  logic            rmw_illegal_s;

  csr_rmw_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_rmw (
    .op_i           (bus.csr_op_in),
    .old_i          (old_q),
    .pre_data_i     (bus.pre_data_in),
    .src_zero_i     (bus.src_zero_in),
    .addr_i         (bus.csr_addr_in),
    .new_value_o    (rmw_new_s),
    .write_enable_o (rmw_we_s),
    .illegal_o      (rmw_illegal_s)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      old_q   <= {XLEN{1'b0}};
    end else begin
      state_q <= state_d;
      old_q   <= old_d;
    end
  end

  // Outputs are decoded from the state register; arbitration only in IDLE.
  always_comb begin
    state_d             = state_q;
    old_d               = old_q;
    bus.csr_addr_out    = {ADDR_W{1'b0}};
    bus.csr_wr_en_out   = 1'b0;
    bus.csr_wr_data_out = {XLEN{1'b0}};
    bus.rd_data_out     = {XLEN{1'b0}};
    bus.csr_done_out    = 1'b0;
    bus.trap_done_out   = 1'b0;
    bus.mret_done_out   = 1'b0;
    bus.illegal_out     = 1'b0;
    bus.stall_out       = 1'b1;
    case (state_q)
      ST_IDLE: begin
        bus.stall_out = bus.trap_req_in | bus.mret_req_in | bus.csr_req_in;
        if (bus.trap_req_in) begin
          state_d = ST_TRAP_EPC;
        end else if (bus.mret_req_in) begin
          state_d = ST_MRET_RD;
        end else if (bus.csr_req_in) begin
          state_d = ST_CSR_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CSR_RD: begin
        bus.csr_addr_out = bus.csr_addr_in;
        old_d            = bus.csr_rd_data_in;
        state_d          = ST_CSR_WR;
      end
      ST_CSR_WR: begin
        bus.csr_addr_out    = bus.csr_addr_in;
        bus.csr_wr_en_out   = rmw_we_s;
        bus.csr_wr_data_out = rmw_new_s;
        bus.rd_data_out     = old_q;
        bus.csr_done_out    = 1'b1;
        bus.illegal_out     = rmw_illegal_s;
        state_d             = ST_IDLE;
      end
      ST_TRAP_EPC: begin
        bus.csr_addr_out    = ADDR_W'(CSR_MEPC);
        bus.csr_wr_en_out   = 1'b1;
        bus.csr_wr_data_out = bus.trap_pc_in & ~{{(XLEN-2){1'b0}}, 2'b11};
        state_d             = ST_TRAP_CAUSE;
      end
      ST_TRAP_CAUSE: begin
        bus.csr_addr_out    = ADDR_W'(CSR_MCAUSE);
        bus.csr_wr_en_out   = 1'b1;
        bus.csr_wr_data_out = bus.trap_cause_in;
        state_d             = ST_TRAP_STAT;
      end
      ST_TRAP_STAT: begin
        bus.csr_addr_out    = ADDR_W'(CSR_MSTATUS);
        bus.csr_wr_en_out   = 1'b1;
        bus.csr_wr_data_out = trap_mstatus(bus.csr_rd_data_in);
        bus.trap_done_out   = 1'b1;
        state_d             = ST_IDLE;
      end
      ST_MRET_RD: begin
        bus.csr_addr_out = ADDR_W'(CSR_MSTATUS);
        old_d            = bus.csr_rd_data_in;
        state_d          = ST_MRET_WR;
      end
      ST_MRET_WR: begin
        bus.csr_addr_out    = ADDR_W'(CSR_MSTATUS);
        bus.csr_wr_en_out   = 1'b1;
        bus.csr_wr_data_out = mret_mstatus(old_q);
        bus.mret_done_out   = 1'b1;
        state_d             = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_seq_ctrl.sv
// Directed bench for csr_seq_ctrl: Zicsr RMW cases, trap/MRET sequences,
// arbitration priority and reset abort, all against hand-computed values.
module tb_csr_seq_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  csr_seq_ctrl_if bus ();

  csr_seq_ctrl dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // {csr_done, trap_done, mret_done, illegal}
  function automatic logic [31:0] pulses();
    return 32'({bus.csr_done_out, bus.trap_done_out, bus.mret_done_out, bus.illegal_out});
  endfunction

  task automatic clear_inputs();
    bus.csr_req_in     = 1'b0;
    bus.csr_op_in      = 3'b000;
    bus.csr_addr_in    = 12'h000;
    bus.pre_data_in    = 32'h0;
    bus.src_zero_in    = 1'b0;
    bus.trap_req_in    = 1'b0;
    bus.trap_pc_in     = 32'h0;
    bus.trap_cause_in  = 32'h0;
    bus.mret_req_in    = 1'b0;
    bus.csr_rd_data_in = 32'h0;
  endtask

  task automatic run_csr(input string tag, input logic [2:0] op, input logic [11:0] addr,
                         input logic [31:0] pre, input logic sz, input logic [31:0] file_val,
                         input logic exp_we, input logic [31:0] exp_wd, input logic exp_ill);
    next_cycle();
    bus.csr_req_in     = 1'b1;
    bus.csr_op_in      = op;
    bus.csr_addr_in    = addr;
    bus.pre_data_in    = pre;
    bus.src_zero_in    = sz;
    bus.csr_rd_data_in = file_val;
    @(negedge clk);
    check_eq({tag, "_c0_stall"}, 32'(bus.stall_out), 32'h1);
    check_eq({tag, "_c0_pulses"}, pulses(), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_c1_addr"}, 32'(bus.csr_addr_out), 32'(addr));
    check_eq({tag, "_c1_wen"}, 32'(bus.csr_wr_en_out), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq({tag, "_c2_wen"}, 32'(bus.csr_wr_en_out), 32'(exp_we));
    if (exp_we) check_eq({tag, "_c2_wdata"}, bus.csr_wr_data_out, exp_wd);
    check_eq({tag, "_c2_rd"}, bus.rd_data_out, file_val);
    check_eq({tag, "_c2_pulses"}, pulses(), {28'd0, 3'b100, exp_ill});
    check_eq({tag, "_c2_stall"}, 32'(bus.stall_out), 32'h1);
    next_cycle();
    bus.csr_req_in = 1'b0;
    @(negedge clk);
    check_eq({tag, "_c3_stall"}, 32'(bus.stall_out), 32'h0);
    check_eq({tag, "_c3_pulses"}, pulses(), 32'h0);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    clear_inputs();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_pulses", pulses(), 32'h0);
    check_eq("rst_stall", 32'(bus.stall_out), 32'h0);
    check_eq("rst_wen", 32'(bus.csr_wr_en_out), 32'h0);
    check_eq("rst_addr", 32'(bus.csr_addr_out), 32'h0);
    check_eq("rst_wdata", bus.csr_wr_data_out, 32'h0);
    check_eq("rst_rd", bus.rd_data_out, 32'h0);
    rst = 1'b0;

    //       tag       op      addr     pre           sz    file          we    wdata         ill
    run_csr("rs_mst",  3'b010, 12'h300, 32'h0000_0008, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0008, 1'b0);
    run_csr("rci_z",   3'b111, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_1888, 1'b0, 32'h0,         1'b0);
    run_csr("rw_misa", 3'b001, 12'h301, 32'hFFFF_FFFF, 1'b0, 32'h4000_0100, 1'b0, 32'h0,         1'b0);
    run_csr("rw_ro",   3'b001, 12'hF11, 32'h0000_1234, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b1);
    run_csr("rc_mepc", 3'b011, 12'h341, 32'h0000_00F0, 1'b0, 32'h0000_0FFF, 1'b1, 32'h0000_0F0F, 1'b0);
    run_csr("rsi_ro0", 3'b110, 12'hF11, 32'h0000_0000, 1'b1, 32'h0000_0055, 1'b0, 32'h0,         1'b0);
    run_csr("f3_000",  3'b000, 12'h300, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b1);
    run_csr("f3_100",  3'b100, 12'h300, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b0, 32'h0,         1'b1);
    run_csr("rwi_z",   3'b101, 12'h340, 32'h0000_001F, 1'b1, 32'h0000_0007, 1'b1, 32'h0000_001F, 1'b0);
    run_csr("rs_mca",  3'b010, 12'h342, 32'h0000_0005, 1'b0, 32'h0000_000A, 1'b1, 32'h0000_000F, 1'b0);

    // All three requests at once: trap first, then MRET, then the Zicsr op.
    next_cycle();
    bus.trap_req_in    = 1'b1;
    bus.mret_req_in    = 1'b1;
    bus.csr_req_in     = 1'b1;
    bus.csr_op_in      = 3'b010;
    bus.csr_addr_in    = 12'h300;
    bus.pre_data_in    = 32'h0;
    bus.src_zero_in    = 1'b1;
    bus.trap_pc_in     = 32'h0000_1006;
    bus.trap_cause_in  = 32'h8000_0007;
    bus.csr_rd_data_in = 32'h0000_0008;
    @(negedge clk);
    check_eq("trap_c0_stall", 32'(bus.stall_out), 32'h1);
    next_cycle();
    @(negedge clk);
    check_eq("trap_c1_addr", 32'(bus.csr_addr_out), 32'h341);
    check_eq("trap_c1_wen", 32'(bus.csr_wr_en_out), 32'h1);
    check_eq("trap_c1_wdata", bus.csr_wr_data_out, 32'h0000_1004);
    check_eq("trap_c1_pulses", pulses(), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq("trap_c2_addr", 32'(bus.csr_addr_out), 32'h342);
    check_eq("trap_c2_wdata", bus.csr_wr_data_out, 32'h8000_0007);
    check_eq("trap_c2_pulses", pulses(), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq("trap_c3_addr", 32'(bus.csr_addr_out), 32'h300);
    check_eq("trap_c3_wen", 32'(bus.csr_wr_en_out), 32'h1);
    check_eq("trap_c3_wdata", bus.csr_wr_data_out, 32'h0000_1880);
    check_eq("trap_c3_pulses", pulses(), 32'h4);
    next_cycle();
    bus.trap_req_in    = 1'b0;
    bus.csr_rd_data_in = 32'h0000_1880;
    @(negedge clk);
    check_eq("mret_c0_stall", 32'(bus.stall_out), 32'h1);
    check_eq("mret_c0_wen", 32'(bus.csr_wr_en_out), 32'h0);
    next_cycle();
    @(negedge clk);
    check_eq("mret_c1_addr", 32'(bus.csr_addr_out), 32'h300);
    check_eq("mret_c1_wen", 32'(bus.csr_wr_en_out), 32'h0);
    next_cycle();
    bus.csr_rd_data_in = 32'h0000_0000;
    @(negedge clk);
    check_eq("mret_c2_wen", 32'(bus.csr_wr_en_out), 32'h1);
    check_eq("mret_c2_wdata", bus.csr_wr_data_out, 32'h0000_1888);
    check_eq("mret_c2_pulses", pulses(), 32'h2);
    next_cycle();
    bus.mret_req_in    = 1'b0;
    bus.csr_rd_data_in = 32'h0000_1888;
    @(negedge clk);
    check_eq("late_csr_c0_stall", 32'(bus.stall_out), 32'h1);
    next_cycle();
    @(negedge clk);
    check_eq("late_csr_c1_addr", 32'(bus.csr_addr_out), 32'h300);
    next_cycle();
    @(negedge clk);
    check_eq("late_csr_c2_pulses", pulses(), 32'h8);
    check_eq("late_csr_c2_wen", 32'(bus.csr_wr_en_out), 32'h0);
    check_eq("late_csr_c2_rd", bus.rd_data_out, 32'h0000_1888);
    next_cycle();
    clear_inputs();

    // Reset during TRAP_CAUSE aborts without further writes or trap_done.
    next_cycle();
    bus.trap_req_in   = 1'b1;
    bus.trap_pc_in    = 32'h0000_2000;
    bus.trap_cause_in = 32'h0000_000B;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("abort_c2_addr", 32'(bus.csr_addr_out), 32'h342);
    rst             = 1'b1;
    bus.trap_req_in = 1'b0;
    next_cycle();
    @(negedge clk);
    check_eq("abort_r_pulses", pulses(), 32'h0);
    check_eq("abort_r_wen", 32'(bus.csr_wr_en_out), 32'h0);
    check_eq("abort_r_addr", 32'(bus.csr_addr_out), 32'h0);
    check_eq("abort_r_wdata", bus.csr_wr_data_out, 32'h0);
    check_eq("abort_r_stall", 32'(bus.stall_out), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      @(negedge clk);
      check_eq("abort_post_pulses", pulses(), 32'h0);
      check_eq("abort_post_wen", 32'(bus.csr_wr_en_out), 32'h0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
